multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle MIPS controller: a registered state machine that sequences fetch, decode, execute, memory and write-back over several clocks for every supported opcode. It replaces the single-cycle opcode decoder in the datapath top level. It drives the shared-memory, register-file, ALU and PC-select controls, and waits on a memory-ready handshake. It adds the byte load/store, move, jal-link and illegal-opcode handling that the single-cycle decoder lacks. Memory waits are bounded by a parametrised timeout.

## Interface
- OPCODE_W, 6, opcode field width
- ALUOP_W, 3, ALU operation code width; matches the `ALUop_*` codes
- WAIT_MAX, 16, maximum cycles to wait for mem_ready before faulting; 0 disables the timeout
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag, combinational from the datapath
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  load PC
- ir_write  out  1  load instruction register
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- mem_byte  out  1  byte-wide access (lb/sb)
- reg_write  out  1  register-file write enable
- reg_dst  out  2  write-register select: 0 rt, 1 rd, 2 $31
- mem_to_reg  out  2  write-data select: 0 ALUOut, 1 MDR, 2 PC
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs
- alu_src_b  out  2  ALU B select: 0 rt, 1 constant 4, 2 sign-extended immediate, 3 constant 0
- alu_op  out  ALUOP_W  ALU operation, using the `ALUop_*` codes
- pc_src  out  2  PC source: 0 ALU result, 1 ALUOut (branch target), 2 jump target
- fault  out  1  sticky; illegal opcode or memory timeout
- state_o  out  4  current state, for debug

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB_R, BRANCH, JUMP, TRAP.
- Outputs not listed for a state are 0. The default selector values are 0.
- Outputs decode from the state register. The only exceptions are pc_write and ir_write in FETCH and pc_write in BRANCH, which depend on the inputs.
- **IDLE:** all outputs 0. Always moves to FETCH.
- **FETCH:**
  - mem_read=1, alu_src_b=1, alu_op=ADD.
  - Waits while mem_ready=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 (PC+4), then moves to DECODE.
- **DECODE:**
  - alu_src_b=2 with ADD precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 000000 → EXEC_R
    - addi/subi/andi/ori/slti/move → EXEC_I
    - lw/sw/lb/sb → MEM_ADDR
    - beq/bne → BRANCH
    - j/jal → JUMP
    - any other opcode → TRAP
- **EXEC_R:** alu_src_a=1, alu_src_b=0, alu_op=RTYPE. Moves to WB_R.
- **WB_R:** reg_write=1, reg_dst=1. Moves to FETCH.
- **EXEC_I:**
  - alu_src_a=1, alu_src_b=2.
  - alu_op per opcode: ADD, SUB, AND, OR, LESS (slti).
  - move uses alu_src_b=3 with ADD.
  - Moves to MEM_WB with mem_to_reg=0.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=2, alu_op=ADD. Loads go to MEM_RD, stores go to MEM_WR.
- **MEM_RD / MEM_WR:**
  - i_or_d=1, strobe held, mem_byte=1 for lb/sb.
  - Waits while mem_ready=0.
  - On mem_ready=1: MEM_RD moves to MEM_WB (load); MEM_WR moves to FETCH.
- **MEM_WB:**
  - reg_write=1, reg_dst=0.
  - mem_to_reg=1 for loads, 0 for EXEC_I results.
  - Moves to FETCH.
- **BRANCH:**
  - alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_write = zero for beq, !zero for bne.
  - Moves to FETCH.
- **JUMP:**
  - pc_src=2, pc_write=1.
  - jal additionally sets reg_write=1, reg_dst=2, mem_to_reg=2 (PC already +4).
  - Moves to FETCH.
- **TRAP:** fault=1, all other outputs 0. Stays in TRAP until reset.
- **Wait timer:**
  - Counts cycles spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on every state change.
  - When the count reaches WAIT_MAX (WAIT_MAX>0), the next state is TRAP.

## Timing
- **Reset:** asynchronously forces state=IDLE, wait count=0, fault=0, so all outputs read 0 during reset. First FETCH occurs on the second rising edge after reset deasserts.
- **Reset mid-instruction:** the in-flight instruction is abandoned. No partial PC or register write occurs after the reset assertion.
- **Latency with mem_ready tied high:**
  - R-type, I-type ALU and move: 4 cycles
  - lw/lb: 5 cycles
  - sw/sb: 4 cycles
  - beq/bne: 3 cycles
  - j/jal: 3 cycles
- Each cycle with mem_ready=0 adds one cycle.
- **Memory handshake:**
  - Strobes and address select are stable for the whole wait.
  - mem_ready is sampled only in the three memory states; it is ignored elsewhere.
- **Timeout vs. completion:** when mem_ready=1 arrives in the same cycle the count reaches WAIT_MAX, completion wins.

## Structure
- `mips_defines.vh` holds:
  - opcode localparams (moved out of the decoder)
  - the `ALUop_*` codes
  - state encodings
  - the reg_dst/mem_to_reg/alu_src_b/pc_src selector encodings
- One sub-module: mc_wait_timer, a WAIT_MAX-bounded counter with clear/enable/expired.

## Test plan
- **Reset, then add (opcode 0), mem_ready=1:** states IDLE→FETCH→DECODE→EXEC_R→WB_R; reg_write=1 with reg_dst=1 only in cycle 4 after FETCH.
- **lw with mem_ready low for 3 cycles in MEM_RD:** mem_read and i_or_d held for 4 cycles; MEM_WB follows with mem_to_reg=1; total 8 cycles.
- **beq:** zero=1 gives pc_write=1, pc_src=1 in BRANCH; zero=0 gives pc_write=0. bne is the inverse.
- **jal:** JUMP asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; the next state is FETCH.
- **Opcode 6'b110110:** TRAP after DECODE; fault stays 1 for 20 cycles; reset clears it and IDLE returns.
- **WAIT_MAX=4, mem_ready held 0 in FETCH:** TRAP entered after 4 wait cycles. A repeat run with mem_ready=1 on the 4th cycle proceeds to DECODE.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU codes,
// state encodings, datapath selector values and the control-word bundle.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_MOVE  = 6'b010100;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUop_AND   = 3'b000;
    localparam logic [2:0] ALUop_OR    = 3'b001;
    localparam logic [2:0] ALUop_ADD   = 3'b010;
    localparam logic [2:0] ALUop_RTYPE = 3'b100;
    localparam logic [2:0] ALUop_SUB   = 3'b110;
    localparam logic [2:0] ALUop_LESS  = 3'b111;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_WB_R     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic       ALUA_PC = 1'b0;
    localparam logic       ALUA_RS = 1'b1;

    localparam logic [1:0] ALUB_RT   = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd2;
    localparam logic [1:0] ALUB_ZERO = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       fault;
    } ctrl_t;

    function automatic logic [3:0] dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                                          return S_EXEC_R;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_MOVE: return S_EXEC_I;
            OP_LW, OP_SW, OP_LB, OP_SB:                        return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                                    return S_BRANCH;
            OP_J, OP_JAL:                                      return S_JUMP;
            default:                                           return S_TRAP;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB);
    endfunction

    function automatic logic [2:0] itype_aluop(input logic [5:0] op);
        case (op)
            OP_SUBI: return ALUop_SUB;
            OP_ANDI: return ALUop_AND;
            OP_ORI:  return ALUop_OR;
            OP_SLTI: return ALUop_LESS;
            default: return ALUop_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles and flags the WAIT_MAX-th one.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry fires during the WAIT_MAX-th stalled cycle; a ready cycle never counts.
    assign expired_o = (WAIT_MAX != 0) && en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o && (WAIT_MAX != 0)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/write-back
// with a memory-ready handshake, bounded waits and a sticky trap state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_byte,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                fault,
    output logic [3:0]          state_o
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] op;
    logic       wait_en;
    logic       wait_expired;
    ctrl_t      ctrl;

    assign op = 6'(opcode);

    assign wait_en = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                     && !mem_ready;

    mc_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk_i    (clk),
        .rst_i    (reset),
        .clear_i  (state_d != state_q),
        .en_i     (wait_en),
        .expired_o(wait_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)         state_d = S_DECODE;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_DECODE:   state_d = dispatch(op);
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_MEM_WB;
            S_MEM_ADDR: state_d = is_load(op) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)         state_d = S_MEM_WB;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)         state_d = S_FETCH;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode except the FETCH handshake and the BRANCH condition.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUop_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_a = ALUA_PC;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUop_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = ALUA_RS;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUop_RTYPE;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RD;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = ALUA_RS;
                ctrl.alu_src_b = (op == OP_MOVE) ? ALUB_ZERO : ALUB_IMM;
                ctrl.alu_op    = itype_aluop(op);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = ALUA_RS;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUop_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mem_byte = (op == OP_LB);
            end
            S_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.mem_byte  = (op == OP_SB);
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = is_load(op) ? M2R_MDR : M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = ALUA_RS;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUop_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_write  = (op == OP_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                if (op == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            S_TRAP: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_byte   = ctrl.mem_byte;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ALUOP_W'(ctrl.alu_op);
    assign pc_src     = ctrl.pc_src;
    assign fault      = ctrl.fault;
    assign state_o    = state_q;

endmodule
